pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 22 ++
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port between the PC sequencer (master) and
// the instruction memory (slave).
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: alternates FETCH and EXEC, selects the next PC,
// counts retired instructions and stops in a sticky HALT state on request or fault.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int          TIMEOUT       = 16,
  parameter logic [31:0] INSTRET_RESET = 32'h0000_0000  // reset value of instret, normally zero
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master imem,
  output logic [31:0]    PC,
  output logic [31:0]    Instr,
  output logic           instr_valid,
  input  logic [1:0]     PCSrc,
  input  logic [31:0]    PCPlus4,
  input  logic [31:0]    PCTarget,
  input  logic [31:0]    ALUResult,
  input  logic           stall,
  output logic           halted,
  output logic           err,
  output logic [31:0]    instret
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         instret_q, instret_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic [31:0]         next_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_VECTOR;
      instr_q   <= 32'h0;
      instret_q <= INSTRET_RESET;
      wait_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    wait_d    = wait_q;
    err_d     = err_q;
    next_pc   = pc_q;

    unique case (PCSrc)
      2'b00:   next_pc = PCPlus4;
      2'b01:   next_pc = PCTarget;
      2'b10:   next_pc = ALUResult & 32'hFFFF_FFFE;
      default: next_pc = pc_q;
    endcase

    case (state_q)
      S_FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = S_EXEC;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          // TIMEOUT consecutive empty cycles, counting this one
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (PCSrc == 2'b11) begin
            instret_d = instret_q + 32'd1;
            state_d   = S_HALT;
          end else if (next_pc[1:0] != 2'b00) begin
            // misaligned target: keep PC so the faulting instruction is visible
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d      = next_pc;
            instret_d = instret_q + 32'd1;
            wait_d    = '0;
            state_d   = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end
    endcase
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign PC             = pc_q;
  assign Instr          = instr_q;
  assign instr_valid    = (state_q == S_EXEC);
  assign halted         = (state_q == S_HALT);
  assign err            = err_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer: the driver pushes expected
// retire/halt/reset records, a negedge monitor pops and compares them.
module tb_pc_sequencer;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] RV      = 32'h0000_0000;
  localparam logic [31:0] W_RV    = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  PCSrc;
  logic [31:0] PCPlus4, PCTarget, ALUResult;
  logic        stall;
  logic [31:0] PC, Instr, instret;
  logic        instr_valid, halted, err;

  logic [31:0] w_pc, w_instr, w_instret;
  logic        w_valid, w_halted, w_err;

  always #5 clk = ~clk;

  pc_sequencer_if imem_if ();
  pc_sequencer_if wrap_if ();

  pc_sequencer #(.RESET_VECTOR(RV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .imem(imem_if),
    .PC(PC), .Instr(Instr), .instr_valid(instr_valid),
    .PCSrc(PCSrc), .PCPlus4(PCPlus4), .PCTarget(PCTarget), .ALUResult(ALUResult),
    .stall(stall), .halted(halted), .err(err), .instret(instret)
  );

  // Second instance starts instret at all-ones to observe the wrap on its first retire
  assign wrap_if.imem_ready = 1'b1;
  assign wrap_if.imem_rdata = 32'h0000_0013;

  pc_sequencer #(.RESET_VECTOR(W_RV), .TIMEOUT(TIMEOUT), .INSTRET_RESET(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .reset(reset), .imem(wrap_if),
    .PC(w_pc), .Instr(w_instr), .instr_valid(w_valid),
    .PCSrc(2'b00), .PCPlus4(w_pc + 32'd4), .PCTarget(32'h0), .ALUResult(32'h0),
    .stall(1'b0), .halted(w_halted), .err(w_err), .instret(w_instret)
  );

  typedef enum int {K_RESET, K_EXEC, K_HALT} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instret;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_pc;
  logic [31:0] ref_instret;
  int          rst_cnt = 0;
  int          w_cyc = 3;
  logic        halted_prev = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic bit take(kind_e k, output exp_t e);
    checks++;
    if (q.size() == 0 || q[0].kind != k) begin
      errors++;
      $display("FAIL record_%s: no matching expectation (queue size %0d)", k.name(), q.size());
      return 1'b0;
    end
    e = q.pop_front();
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    rst_cnt <= reset ? rst_cnt + 1 : 0;
    w_cyc   <= reset ? 0 : ((w_cyc < 3) ? w_cyc + 1 : w_cyc);
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_cnt == 1) begin
      if (take(K_RESET, e)) begin
        chk("reset_pc", PC, e.pc);
        chk("reset_instr", Instr, 32'h0);
        chk("reset_valid", {31'h0, instr_valid}, 32'h0);
        chk("reset_req", {31'h0, imem_if.imem_req}, 32'h1);
        chk("reset_halted", {31'h0, halted}, 32'h0);
        chk("reset_err", {31'h0, err}, 32'h0);
        chk("reset_instret", instret, 32'h0);
        chk("wrap_reset_instret", w_instret, 32'hFFFF_FFFF);
      end
    end else if (rst_cnt == 0) begin
      chk("addr_eq_pc", imem_if.imem_addr, PC);
      if (instr_valid && !stall) begin
        if (take(K_EXEC, e)) begin
          chk("exec_pc", PC, e.pc);
          chk("exec_instr", Instr, e.instr);
          chk("exec_instret", instret, e.instret);
          chk("exec_flags", {30'h0, halted, err}, 32'h0);
        end
      end else if (instr_valid && stall && q.size() != 0 && q[0].kind == K_EXEC) begin
        chk("stall_pc", PC, q[0].pc);
        chk("stall_instr", Instr, q[0].instr);
        chk("stall_instret", instret, q[0].instret);
      end
      if (halted && !halted_prev) begin
        if (take(K_HALT, e)) begin
          chk("halt_pc", PC, e.pc);
          chk("halt_instret", instret, e.instret);
          chk("halt_err", {31'h0, err}, {31'h0, e.err});
        end
      end
      if (halted_prev) chk("halt_sticky", {31'h0, halted}, 32'h1);
      if (halted) chk("halt_req_valid", {30'h0, imem_if.imem_req, instr_valid}, 32'h0);
      if (w_cyc == 1) begin
        chk("wrap_valid", {31'h0, w_valid}, 32'h1);
        chk("wrap_instr", w_instr, 32'h0000_0013);
        chk("wrap_pre_instret", w_instret, 32'hFFFF_FFFF);
      end else if (w_cyc == 2) begin
        chk("wrap_instret", w_instret, 32'h0);
        chk("wrap_pc", w_pc, W_RV + 32'd4);
        chk("wrap_addr", wrap_if.imem_addr, W_RV + 32'd4);
        chk("wrap_state", {29'h0, wrap_if.imem_req, w_halted, w_err}, 32'h4);
      end
    end
    halted_prev = halted;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_side();
    PCSrc     = 2'($urandom);
    stall     = 1'($urandom);
    PCPlus4   = $urandom;
    PCTarget  = $urandom;
    ALUResult = $urandom;
  endtask

  task automatic do_reset();
    q.push_back('{kind: K_RESET, pc: RV, instr: 32'h0, instret: 32'h0, err: 1'b0});
    reset = 1'b1;
    imem_if.imem_ready = 1'($urandom);
    imem_if.imem_rdata = $urandom;
    rand_side();
    step();
    step();
    reset = 1'b0;
    ref_pc = RV;
    ref_instret = 32'h0;
  endtask

  task automatic hold_halt(int n);
    for (int i = 0; i < n; i++) begin
      imem_if.imem_ready = 1'($urandom);
      imem_if.imem_rdata = $urandom;
      rand_side();
      step();
    end
  endtask

  // One fetch (lat empty cycles first) and its EXEC phase; h reports a halt
  task automatic run_txn(int lat, logic [31:0] word, int stalls, logic [1:0] src,
                         logic [31:0] p4, logic [31:0] tgt, logic [31:0] alu,
                         output bit h);
    logic [31:0] nxt;
    h = 1'b0;
    if (lat >= TIMEOUT)
      q.push_back('{kind: K_HALT, pc: ref_pc, instr: 32'h0, instret: ref_instret, err: 1'b1});
    for (int i = 0; i < lat && i < TIMEOUT; i++) begin
      imem_if.imem_ready = 1'b0;
      imem_if.imem_rdata = $urandom;
      rand_side();
      step();
    end
    if (lat >= TIMEOUT) begin
      h = 1'b1;
      return;
    end
    imem_if.imem_ready = 1'b1;
    imem_if.imem_rdata = word;
    rand_side();
    step();
    q.push_back('{kind: K_EXEC, pc: ref_pc, instr: word, instret: ref_instret, err: 1'b0});
    if (src == 2'b11) begin
      ref_instret = ref_instret + 1;
      q.push_back('{kind: K_HALT, pc: ref_pc, instr: 32'h0, instret: ref_instret, err: 1'b0});
      h = 1'b1;
    end else begin
      nxt = (src == 2'b00) ? p4 : (src == 2'b01) ? tgt : (alu / 2) * 2;
      if (nxt % 4 != 0) begin
        q.push_back('{kind: K_HALT, pc: ref_pc, instr: 32'h0, instret: ref_instret, err: 1'b1});
        h = 1'b1;
      end else begin
        ref_pc = nxt;
        ref_instret = ref_instret + 1;
      end
    end
    for (int s = 0; s < stalls; s++) begin
      rand_side();
      stall = 1'b1;
      imem_if.imem_ready = 1'($urandom);
      imem_if.imem_rdata = $urandom;
      step();
    end
    stall = 1'b0;
    PCSrc = src;
    PCPlus4 = p4;
    PCTarget = tgt;
    ALUResult = alu;
    imem_if.imem_ready = 1'($urandom);
    imem_if.imem_rdata = $urandom;
    step();
  endtask

  initial begin
    bit h;
    int r, lat;
    logic [1:0]  src;
    logic [31:0] tgt, alu;
    reset = 1'b1;
    stall = 1'b0;
    PCSrc = 2'b00;
    PCPlus4 = 32'h0;
    PCTarget = 32'h0;
    ALUResult = 32'h0;
    imem_if.imem_ready = 1'b0;
    imem_if.imem_rdata = 32'h0;
    do_reset();

    // sequential run 0,4,8,12 then 0x10, branch to 0x40, jump via ALU 0x81 -> 0x80
    for (int i = 0; i < 4; i++)
      run_txn(0, 32'h1000_0000 + i, 0, 2'b00, ref_pc + 4, $urandom, $urandom, h);
    run_txn(0, 32'hAAAA_0001, 0, 2'b01, ref_pc + 4, 32'h40, $urandom, h);
    run_txn(0, 32'hAAAA_0002, 0, 2'b10, ref_pc + 4, $urandom, 32'h81, h);
    run_txn(0, 32'hBBBB_0003, 3, 2'b00, ref_pc + 4, $urandom, $urandom, h);
    run_txn(15, 32'hCCCC_0004, 0, 2'b00, ref_pc + 4, $urandom, $urandom, h);
    run_txn(16, 32'h0, 0, 2'b00, 32'h0, 32'h0, 32'h0, h);
    hold_halt(5);
    do_reset();

    // misaligned branch target from PC 0x10
    for (int i = 0; i < 4; i++)
      run_txn(1, $urandom, 0, 2'b00, ref_pc + 4, $urandom, $urandom, h);
    run_txn(0, 32'hDDDD_0005, 0, 2'b01, ref_pc + 4, 32'h42, $urandom, h);
    hold_halt(4);
    do_reset();

    // reset in the middle of a fetch wait; the wait count must restart
    for (int i = 0; i < 5; i++) begin
      imem_if.imem_ready = 1'b0;
      rand_side();
      step();
    end
    do_reset();
    run_txn(15, 32'hEEEE_0006, 1, 2'b00, ref_pc + 4, $urandom, $urandom, h);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 15);
      src = (r < 8) ? 2'b00 : (r < 11) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
      tgt = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      alu = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
      lat = ($urandom_range(0, 19) == 0) ? $urandom_range(15, 16) : $urandom_range(0, 3);
      run_txn(lat, $urandom, $urandom_range(0, 2), src, ref_pc + 4, tgt, alu, h);
      if (h) begin
        hold_halt($urandom_range(1, 4));
        do_reset();
      end
    end

    run_txn(0, 32'hFFFF_0007, 0, 2'b11, ref_pc + 4, $urandom, $urandom, h);
    hold_halt(3);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
